// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_pkg : state encodings and derived-count helpers for alarm_ring_ctrl |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package alarm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  function automatic int half_cyc(input int clk_freq, input int tone_hz);
    return clk_freq / (2 * tone_hz);
  endfunction

  function automatic int gate_per(input int clk_freq);
    return clk_freq / 2;
  endfunction

  function automatic int sec_cyc(input int clk_freq);
    return clk_freq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_ring_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_ring_ctrl_if : control, BCD time and piezo/status signals            |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
interface alarm_ring_ctrl_if;
  logic       ring;
  logic       ack;
  logic       snooze;
  logic [2:0] cur_h_ten;
  logic [3:0] cur_h_one;
  logic [2:0] cur_m_ten;
  logic [3:0] cur_m_one;
  logic [2:0] alm_h_ten;
  logic [3:0] alm_h_one;
  logic [2:0] alm_m_ten;
  logic [3:0] alm_m_one;
  logic       beep;
  logic       ringing;
  logic       snoozing;

  modport master (
    output ring, ack, snooze,
    output cur_h_ten, cur_h_one, cur_m_ten, cur_m_one,
    output alm_h_ten, alm_h_one, alm_m_ten, alm_m_one,
    input  beep, ringing, snoozing
  );

  modport slave (
    input  ring, ack, snooze,
    input  cur_h_ten, cur_h_one, cur_m_ten, cur_m_one,
    input  alm_h_ten, alm_h_one, alm_m_ten, alm_m_one,
    output beep, ringing, snoozing
  );
endinterface
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tone_gen : square-wave tone divider gated into two bursts per second       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tone_gen
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TONE_HZ  = 2_000
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic en,
  output logic beep
);

  localparam int HALF     = half_cyc(CLK_FREQ, TONE_HZ);
  localparam int GATE_PER = gate_per(CLK_FREQ);
  localparam int GATE_ON  = CLK_FREQ / 4;
  localparam int HALF_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GATE_W   = (GATE_PER > 1) ? $clog2(GATE_PER) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_PER - 1);
  localparam logic [GATE_W-1:0] GATE_ONC  = GATE_W'(GATE_ON);

  logic              active_q, active_d;
  logic              tone_q, tone_d;
  logic              beep_q, beep_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;

  always_comb begin
    active_d   = en;
    half_cnt_d = '0;
    gate_cnt_d = '0;
    tone_d     = 1'b0;
    beep_d     = 1'b0;
    if (en) begin
      // First enabled cycle and every gate period restart both phases high
      if (!active_q || (gate_cnt_q == GATE_LAST)) begin
        tone_d = 1'b1;
      end else begin
        gate_cnt_d = gate_cnt_q + GATE_W'(1);
        if (half_cnt_q == HALF_LAST) begin
          tone_d = ~tone_q;
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
          tone_d     = tone_q;
        end
      end
      beep_d = tone_d & (gate_cnt_d < GATE_ONC);
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      tone_q     <= 1'b0;
      beep_q     <= 1'b0;
      half_cnt_q <= '0;
      gate_cnt_q <= '0;
    end else begin
      active_q   <= active_d;
      tone_q     <= tone_d;
      beep_q     <= beep_d;
      half_cnt_q <= half_cnt_d;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  assign beep = beep_q;

endmodule
`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_ring_ctrl : HH:MM alarm compare, ring/snooze FSM and piezo drive     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TONE_HZ        = 2_000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic              mclk,
  input  logic              rst_n,
  alarm_ring_ctrl_if.slave  bus
);

  localparam int SEC   = sec_cyc(CLK_FREQ);
  localparam int MAX_S = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int DIV_W = (SEC > 1) ? $clog2(SEC) : 1;
  localparam int SEC_W = (MAX_S > 1) ? $clog2(MAX_S) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SEC - 1);
  localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_S - 1);

  logic             match, trig, sec_tick, tone_en, tone_beep;
  logic             match_dly_q, match_dly_d;
  logic             ringing_q, ringing_d;
  logic             snoozing_q, snoozing_d;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] sec_div_q, sec_div_d;
  logic [SEC_W-1:0] sec_q, sec_d;

  always_comb begin
    match = (bus.cur_h_ten == bus.alm_h_ten) && (bus.cur_h_one == bus.alm_h_one) &&
            (bus.cur_m_ten == bus.alm_m_ten) && (bus.cur_m_one == bus.alm_m_one);
    trig     = match & ~match_dly_q & bus.ring;
    sec_tick = (sec_div_q == DIV_LAST);

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) state_d = ST_RING;
      end
      ST_RING: begin
        if (!bus.ring || bus.ack)                 state_d = ST_IDLE;
        else if (bus.snooze)                      state_d = ST_SNOOZE;
        else if (sec_tick && (sec_q == RING_LAST)) state_d = ST_IDLE;
      end
      ST_SNOOZE: begin
        if (!bus.ring || bus.ack)                 state_d = ST_IDLE;
        else if (sec_tick && (sec_q == SNZ_LAST))  state_d = ST_RING;
      end
      default: state_d = ST_IDLE;
    endcase

    // Time bases restart on every state change so each RING/SNOOZE is timed from 0
    sec_div_d = sec_div_q;
    sec_d     = sec_q;
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      sec_div_d = '0;
      sec_d     = '0;
    end else if (sec_tick) begin
      sec_div_d = '0;
      sec_d     = sec_q + SEC_W'(1);
    end else begin
      sec_div_d = sec_div_q + DIV_W'(1);
    end

    match_dly_d = match;
    ringing_d   = (state_d == ST_RING);
    snoozing_d  = (state_d == ST_SNOOZE);
    tone_en     = (state_d == ST_RING);
  end

  // match_dly resets high so equal times at reset release cannot trigger
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      match_dly_q <= 1'b1;
      ringing_q   <= 1'b0;
      snoozing_q  <= 1'b0;
      sec_div_q   <= '0;
      sec_q       <= '0;
    end else begin
      state_q     <= state_d;
      match_dly_q <= match_dly_d;
      ringing_q   <= ringing_d;
      snoozing_q  <= snoozing_d;
      sec_div_q   <= sec_div_d;
      sec_q       <= sec_d;
    end
  end

  tone_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TONE_HZ  (TONE_HZ)
  ) u_tone_gen (
    .mclk  (mclk),
    .rst_n (rst_n),
    .en    (tone_en),
    .beep  (tone_beep)
  );

  assign bus.beep     = tone_beep;
  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_alarm_ring_ctrl : randomized bench against a cycle-count reference model |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_alarm_ring_ctrl;

  localparam int CLK_FREQ       = 1000;
  localparam int TONE_HZ        = 100;
  localparam int RING_TIMEOUT_S = 3;
  localparam int SNOOZE_S       = 2;

  localparam int RING_CYC  = RING_TIMEOUT_S * CLK_FREQ;
  localparam int SNZ_CYC   = SNOOZE_S * CLK_FREQ;
  localparam int HALF_CYC  = CLK_FREQ / (2 * TONE_HZ);
  localparam int BURST_PER = CLK_FREQ / 2;
  localparam int BURST_ON  = CLK_FREQ / 4;

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;

  alarm_ring_ctrl_if bus();

  alarm_ring_ctrl #(
    .CLK_FREQ       (CLK_FREQ),
    .TONE_HZ        (TONE_HZ),
    .RING_TIMEOUT_S (RING_TIMEOUT_S),
    .SNOOZE_S       (SNOOZE_S)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode plus cycles elapsed since entering it
  typedef enum int {M_IDLE, M_RING, M_SNOOZE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_t    = 0;
  bit    m_prev = 1'b1;

  function automatic int cur_minutes();
    return (int'(bus.cur_h_ten) * 10 + int'(bus.cur_h_one)) * 60 +
            int'(bus.cur_m_ten) * 10 + int'(bus.cur_m_one);
  endfunction

  function automatic int alm_minutes();
    return (int'(bus.alm_h_ten) * 10 + int'(bus.alm_h_one)) * 60 +
            int'(bus.alm_m_ten) * 10 + int'(bus.alm_m_one);
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_t    = 0;
    m_prev = 1'b1;
  endfunction

  function automatic void model_step();
    bit    match;
    bit    trig;
    mode_t nxt;
    match = (cur_minutes() == alm_minutes());
    trig  = match && !m_prev && (bus.ring === 1'b1);
    nxt   = m_mode;
    case (m_mode)
      M_IDLE:   if (trig) nxt = M_RING;
      M_RING: begin
        if (!bus.ring || bus.ack)    nxt = M_IDLE;
        else if (bus.snooze)         nxt = M_SNOOZE;
        else if (m_t == RING_CYC - 1) nxt = M_IDLE;
      end
      default: begin
        if (!bus.ring || bus.ack)    nxt = M_IDLE;
        else if (m_t == SNZ_CYC - 1) nxt = M_RING;
      end
    endcase
    m_t    = (nxt != m_mode) ? 0 : m_t + 1;
    m_mode = nxt;
    m_prev = match;
  endfunction

  function automatic logic [2:0] model_out();
    int   p;
    logic b;
    p = m_t % BURST_PER;
    b = (m_mode == M_RING) && (p < BURST_ON) && (((p / HALF_CYC) % 2) == 0);
    return {m_mode == M_RING, m_mode == M_SNOOZE, b};
  endfunction

  task automatic tick();
    @(posedge mclk);
    model_step();
    #1;
  endtask

  task automatic set_cur(input int h, input int m);
    bus.cur_h_ten = 3'(h / 10);
    bus.cur_h_one = 4'(h % 10);
    bus.cur_m_ten = 3'(m / 10);
    bus.cur_m_one = 4'(m % 10);
  endtask

  task automatic set_alm(input int h, input int m);
    bus.alm_h_ten = 3'(h / 10);
    bus.alm_h_one = 4'(h % 10);
    bus.alm_m_ten = 3'(m / 10);
    bus.alm_m_one = 4'(m % 10);
  endtask

  task automatic trigger();
    bus.ring = 1'b1;
    set_alm(7, 0);
    set_cur(6, 59);
    tick();
    set_cur(7, 0);
    tick();
  endtask

  task automatic leave_minute();
    set_cur(7, 1);
    tick();
  endtask

  task automatic test_reset();
    logic [2:0] got, exp_v;
    bus.ack = 1'b0;
    bus.snooze = 1'b0;
    bus.ring = 1'b1;
    set_cur(7, 0);
    set_alm(7, 0);
    rst_n = 1'b0;
    #23;
    model_reset();
    got = {bus.ringing, bus.snoozing, bus.beep};
    n_cmp++;
    if (got !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_values got=%b exp=000", got);
    end
    @(negedge mclk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
    end
    n_cmp++;
    if (bus.ringing !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_equal_no_ring got=%b exp=0", bus.ringing);
    end
  endtask

  task automatic test_ring_basic();
    logic [2:0] got, exp_v;
    bus.ring = 1'b1;
    set_alm(7, 0);
    set_cur(6, 59);
    for (int i = 0; i < 3; i++) tick();
    set_cur(7, 0);
    tick();
    n_cmp++;
    if ({bus.ringing, bus.beep} !== 2'b11) begin
      n_bad++;
      $display("FAIL ring_first_cycle got=%b exp=11", {bus.ringing, bus.beep});
    end
    for (int i = 1; i < RING_CYC + 10; i++) begin
      tick();
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL ring_basic cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (i == RING_CYC - 1 || i == RING_CYC) begin
        n_cmp++;
        if (bus.ringing !== (i == RING_CYC - 1)) begin
          n_bad++;
          $display("FAIL ring_timeout cyc=%0d got=%b exp=%b", i, bus.ringing, i == RING_CYC - 1);
        end
      end
    end
    leave_minute();
  endtask

  task automatic test_ack();
    logic [2:0] got, exp_v;
    int n;
    trigger();
    n = int'($urandom_range(10, 600));
    for (int i = 0; i < n; i++) begin
      tick();
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL ack_pre cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    n_cmp++;
    if ({bus.ringing, bus.snoozing, bus.beep} !== 3'b000) begin
      n_bad++;
      $display("FAIL ack_stop got=%b exp=000", {bus.ringing, bus.snoozing, bus.beep});
    end
    for (int i = 0; i < 300; i++) begin
      tick();
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v || got !== 3'b000) begin
        n_bad++;
        $display("FAIL ack_no_rering cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
    end
    leave_minute();
  endtask

  task automatic test_snooze();
    logic [2:0] got, exp_v;
    int n;
    trigger();
    n = int'($urandom_range(1, 400));
    for (int i = 0; i < n; i++) tick();
    bus.snooze = 1'b1;
    tick();
    bus.snooze = 1'b0;
    n_cmp++;
    if ({bus.ringing, bus.snoozing, bus.beep} !== 3'b010) begin
      n_bad++;
      $display("FAIL snooze_enter got=%b exp=010", {bus.ringing, bus.snoozing, bus.beep});
    end
    for (int i = 1; i <= SNZ_CYC + RING_CYC + 20; i++) begin
      tick();
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL snooze_seq cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (i == SNZ_CYC || i == SNZ_CYC + RING_CYC) begin
        n_cmp++;
        if (bus.ringing !== (i == SNZ_CYC)) begin
          n_bad++;
          $display("FAIL snooze_rering cyc=%0d got=%b exp=%b", i, bus.ringing, i == SNZ_CYC);
        end
      end
    end
    leave_minute();
  endtask

  task automatic test_ack_snooze_and_ring_off();
    trigger();
    for (int i = 0; i < 17; i++) tick();
    bus.ack = 1'b1;
    bus.snooze = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.snooze = 1'b0;
    n_cmp++;
    if ({bus.ringing, bus.snoozing, bus.beep} !== model_out() ||
        {bus.ringing, bus.snoozing, bus.beep} !== 3'b000) begin
      n_bad++;
      $display("FAIL ack_snooze_same got=%b exp=000", {bus.ringing, bus.snoozing, bus.beep});
    end
    leave_minute();
    trigger();
    for (int i = 0; i < 9; i++) tick();
    bus.snooze = 1'b1;
    tick();
    bus.snooze = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    bus.ring = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ringing, bus.snoozing, bus.beep} !== 3'b000) begin
      n_bad++;
      $display("FAIL ring_off_in_snooze got=%b exp=000", {bus.ringing, bus.snoozing, bus.beep});
    end
    bus.ring = 1'b1;
    leave_minute();
  endtask

  task automatic test_reset_mid_ring();
    logic [2:0] got, exp_v;
    trigger();
    for (int i = 0; i < 37; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.ringing, bus.snoozing, bus.beep} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid_ring got=%b exp=000", {bus.ringing, bus.snoozing, bus.beep});
    end
    @(negedge mclk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
    end
    leave_minute();
  endtask

  task automatic test_ring_low_at_edge();
    logic [2:0] got, exp_v;
    bus.ring = 1'b0;
    set_alm(7, 0);
    set_cur(6, 59);
    tick();
    set_cur(7, 0);
    for (int i = 0; i < 5; i++) tick();
    bus.ring = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v || bus.ringing !== 1'b0) begin
        n_bad++;
        $display("FAIL ring_late_arm cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
    end
    leave_minute();
  endtask

  task automatic test_random();
    logic [2:0] got, exp_v;
    int sel;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: set_cur(6, 59);
          1: set_cur(7, 0);
          2: set_cur(7, 1);
          default: set_cur(23, 59);
        endcase
      end
      if ($urandom_range(0, 999) == 0) begin
        if ($urandom_range(0, 1) == 0) set_alm(7, 0);
        else set_alm(7, 1);
      end
      if ($urandom_range(0, 1499) == 0) bus.ring = ~bus.ring;
      if ($urandom_range(0, 399) == 0 && bus.ring == 1'b0) bus.ring = 1'b1;
      bus.ack    = ($urandom_range(0, 499) == 0);
      bus.snooze = ($urandom_range(0, 299) == 0);
      tick();
      bus.ack    = 1'b0;
      bus.snooze = 1'b0;
      got = {bus.ringing, bus.snoozing, bus.beep};
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring_basic();
    test_ack();
    test_snooze();
    test_ack_snooze_and_ring_off();
    test_reset_mid_ring();
    test_ring_low_at_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
